// File: rtl/regfile_pkg.sv
// Shared register-file parameters and types.
// Imported by the write-back arbiter and other register-file blocks.
package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int REG_NUM  = 32;
    localparam int REG_ZERO = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Scans upward from last+1, wrapping at N; grant is combinational.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = LW + 1;

    logic [LW-1:0] last;
    logic [LW-1:0] sel;
    logic [IW-1:0] idx;
    logic          found;

    // Pick the first requester after the previous winner.
    always_comb begin
        gnt   = '0;
        sel   = last;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = {1'b0, last} + IW'(k);
            if (idx >= IW'(N))
                idx = idx - IW'(N);
            if (!found && req[idx[LW-1:0]]) begin
                gnt[idx[LW-1:0]] = 1'b1;
                sel              = idx[LW-1:0];
                found            = 1'b1;
            end
        end
    end

    // Move the pointer only when something was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= LW'(N - 1);
        else if (found)
            last <= sel;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the register file.
// Shares one write port among NREQ requesters; r0 is never written.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               RegWrite,
    output logic [AW-1:0]      writereg,
    output logic [DW-1:0]      writedata,
    input  logic               resv_valid,
    input  logic [AW-1:0]      resv_addr,
    input  logic [AW-1:0]      chk_addr1,
    input  logic [AW-1:0]      chk_addr2,
    output logic               chk_busy1,
    output logic               chk_busy2,
    output logic [2**AW-1:0]   busy
);

    logic [NREQ-1:0]  gnt;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             xfer;
    logic [2**AW-1:0] busy_nxt;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign xfer      = |(req_valid & gnt);

    // Mux the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Register the write port; r0 writes are acknowledged but dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            writereg  <= '0;
            writedata <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (xfer && sel_addr != AW'(REG_ZERO)) begin
                RegWrite  <= 1'b1;
                writereg  <= sel_addr;
                writedata <= sel_data;
            end
        end
    end

    // Next busy map: clear on write, then set on reserve so set wins.
    always_comb begin
        busy_nxt = busy;
        if (RegWrite)
            busy_nxt[writereg] = 1'b0;
        if (resv_valid && resv_addr != AW'(REG_ZERO))
            busy_nxt[resv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Busy bitmap register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign chk_busy1 = busy[chk_addr1] && (chk_addr1 != AW'(REG_ZERO));
    assign chk_busy2 = busy[chk_addr2] && (chk_addr2 != AW'(REG_ZERO));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               RegWrite;
    logic [AW-1:0]      writereg;
    logic [DW-1:0]      writedata;
    logic               resv_valid;
    logic [AW-1:0]      resv_addr;
    logic [AW-1:0]      chk_addr1;
    logic [AW-1:0]      chk_addr2;
    logic               chk_busy1;
    logic               chk_busy2;
    logic [2**AW-1:0]   busy;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .RegWrite   (RegWrite),
        .writereg   (writereg),
        .writedata  (writedata),
        .resv_valid (resv_valid),
        .resv_addr  (resv_addr),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        resv_valid = 1'b0;
        resv_addr  = '0;
        chk_addr1  = 5'd7;
        chk_addr2  = 5'd0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_writereg", 64'(writereg), 64'd0);
        chk("rst_writedata", 64'(writedata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_chk1", 64'(chk_busy1), 64'd0);
        chk("rst_chk2", 64'(chk_busy2), 64'd0);
        chk("idle_ready", 64'(req_ready), 64'd0);

        // Round-robin: all valid, grants 0,1,2,0,1,2
        set_req(0, 5'd1, 32'hA0);
        set_req(1, 5'd2, 32'hA1);
        set_req(2, 5'd3, 32'hA2);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr_ready%0d", c), 64'(req_ready),
                64'(3'b001 << (c % 3)));
            tick();
            if (c == 5) req_valid = '0;
            chk($sformatf("rr_we%0d", c), 64'(RegWrite), 64'd1);
            chk($sformatf("rr_wreg%0d", c), 64'(writereg),
                64'((c % 3) + 1));
            chk($sformatf("rr_wdata%0d", c), 64'(writedata),
                64'(32'hA0 + (c % 3)));
        end
        tick();
        chk("rr_idle_we", 64'(RegWrite), 64'd0);
        chk("rr_idle_hold", 64'(writereg), 64'd3);

        // Single write to r5
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        chk("sw_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk("sw_we", 64'(RegWrite), 64'd1);
        chk("sw_wreg", 64'(writereg), 64'd5);
        chk("sw_wdata", 64'(writedata), 64'hDEADBEEF);
        tick();
        chk("sw_we_off", 64'(RegWrite), 64'd0);
        chk("sw_hold_data", 64'(writedata), 64'hDEADBEEF);

        // Zero-address drop by requester 1
        set_req(1, 5'd0, 32'h1234);
        req_valid = 3'b010;
        #1;
        chk("z_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        chk("z_we", 64'(RegWrite), 64'd0);
        chk("z_wreg", 64'(writereg), 64'd5);
        chk("z_wdata", 64'(writedata), 64'hDEADBEEF);

        // Reserve r7, and reserving r0 has no effect
        resv_valid = 1'b1;
        resv_addr  = 5'd7;
        tick();
        resv_addr = 5'd0;
        chk("sb_busy7", 64'(busy), 64'h80);
        chk("sb_chk1", 64'(chk_busy1), 64'd1);
        chk("sb_chk2_r0", 64'(chk_busy2), 64'd0);
        tick();
        resv_valid = 1'b0;
        chk("sb_r0_resv", 64'(busy), 64'h80);

        // Write r7 by requester 2; busy clears at the end of N+1
        set_req(2, 5'd7, 32'h77);
        req_valid = 3'b100;
        #1;
        chk("sb_ready2", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        chk("sb_n1_we", 64'(RegWrite), 64'd1);
        chk("sb_n1_busy", 64'(chk_busy1), 64'd1);
        tick();
        chk("sb_n2_busy", 64'(chk_busy1), 64'd0);
        chk("sb_n2_map", 64'(busy), 64'h0);

        // Reserve in the same cycle as the write to r7: set wins
        set_req(0, 5'd7, 32'h78);
        req_valid = 3'b001;
        tick();
        req_valid  = '0;
        resv_valid = 1'b1;
        resv_addr  = 5'd7;
        chk("sw_set_we", 64'(RegWrite), 64'd1);
        chk("sw_set_wreg", 64'(writereg), 64'd7);
        tick();
        resv_valid = 1'b0;
        chk("set_wins", 64'(busy), 64'h80);

        // Double reserve then one write clears it
        resv_valid = 1'b1;
        tick();
        resv_valid = 1'b0;
        chk("dbl_resv", 64'(busy), 64'h80);
        set_req(1, 5'd7, 32'h79);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        tick();
        chk("dbl_clear", 64'(busy), 64'h0);

        // Reset mid-transfer to r9
        chk_addr2  = 5'd9;
        resv_valid = 1'b1;
        resv_addr  = 5'd9;
        tick();
        resv_valid = 1'b0;
        chk("mid_busy9", 64'(chk_busy2), 64'd1);
        set_req(0, 5'd9, 32'h99);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        chk("mid_we_n1", 64'(RegWrite), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_we_rst", 64'(RegWrite), 64'd0);
        chk("mid_wreg_rst", 64'(writereg), 64'd0);
        chk("mid_busy_rst", 64'(busy), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_we_after", 64'(RegWrite), 64'd0);
        chk("mid_chk2", 64'(chk_busy2), 64'd0);

        // Pointer back at NREQ-1 after reset: requester 0 first
        req_valid = 3'b111;
        #1;
        chk("rst_ptr", 64'(req_ready), 64'b001);
        req_valid = 3'b110;
        #1;
        chk("rst_ptr2", 64'(req_ready), 64'b010);
        req_valid = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
